// File: rtl/mipscpu_multicycle.sv
// mipscpu_multicycle
// Multicycle MIPS subset core. It takes one instruction at a time through
// IDLE -> DECODE -> EXEC -> [MEM] -> [WB] -> IDLE. It has a 32-entry register
// file and a word-addressed data memory. The host feeds instructions through
// a valid/ready handshake.
//
// Handshake: an instruction transfers on a rising edge where instr_valid and
// instr_ready are both 1. instr_ready is 1 only in IDLE. A valid instruction
// offered while ready is 0 is neither consumed nor remembered. The host must
// hold it until it sees ready.
//
// Ports
//   clock          single clock, rising edge
//   reset          synchronous, active low
//   instr          instruction word, captured into IR on accept
//   instr_valid    instr holds an instruction
//   instr_ready    core is idle and can accept
//   done           one-cycle retire pulse (registered)
//   illegal        retired instruction was illegal or misaligned (with done)
//   branch_taken   retired beq compared equal (with done)
//   branch_offset  imm field of the retired beq (with done)
//   dbg_addr       debug register read index
//   dbg_data       register[dbg_addr], combinational, 0 for index 0
//   dbg_state      current FSM state encoding
module mipscpu_multicycle #(
  parameter int DATA_W    = 32,
  parameter int MEM_DEPTH = 128
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [31:0]       instr,
  input  logic              instr_valid,
  output logic              instr_ready,
  output logic              done,
  output logic              illegal,
  output logic              branch_taken,
  output logic [15:0]       branch_offset,
  input  logic [4:0]        dbg_addr,
  output logic [DATA_W-1:0] dbg_data,
  output logic [2:0]        dbg_state
);

  localparam int AW = $clog2(MEM_DEPTH);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4
  } state_t;

  state_t state, state_nx;

  logic [31:0]       ir;
  logic [DATA_W-1:0] a_q, b_q, imm_q, alu_q, mdr_q;
  logic [DATA_W-1:0] regs [32];
  logic [DATA_W-1:0] mem  [MEM_DEPTH];

  // Instruction fields
  logic [5:0] opcode, funct;
  logic [4:0] rs, rt, rd, dest;
  logic signed [15:0] imm16;
  logic [DATA_W-1:0]  imm_ext;

  assign opcode  = ir[31:26];
  assign rs      = ir[25:21];
  assign rt      = ir[20:16];
  assign rd      = ir[15:11];
  assign funct   = ir[5:0];
  assign imm16   = ir[15:0];
  assign imm_ext = DATA_W'(imm16);

  logic is_r, is_addi, is_lw, is_sw, is_beq, funct_ok, legal;

  assign is_r     = (opcode == 6'd0);
  assign is_addi  = (opcode == 6'd8);
  assign is_lw    = (opcode == 6'd35);
  assign is_sw    = (opcode == 6'd43);
  assign is_beq   = (opcode == 6'd4);
  assign funct_ok = (funct == 6'd32) || (funct == 6'd34) || (funct == 6'd36) ||
                    (funct == 6'd37) || (funct == 6'd39) || (funct == 6'd42);
  assign legal    = (is_r && funct_ok) || is_addi || is_lw || is_sw || is_beq;
  assign dest     = is_r ? rd : rt;

  // ALU. Operands are the latched A/B/imm, so the result is stable through EXEC.
  logic [DATA_W-1:0] alu_res;
  always_comb begin
    alu_res = a_q + imm_q;
    if (is_r) begin
      case (funct)
        6'd32:   alu_res = a_q + b_q;
        6'd34:   alu_res = a_q - b_q;
        6'd36:   alu_res = a_q & b_q;
        6'd37:   alu_res = a_q | b_q;
        6'd39:   alu_res = ~(a_q | b_q);
        6'd42:   alu_res = DATA_W'(($signed(a_q) < $signed(b_q)) ? 1'b1 : 1'b0);
        default: alu_res = a_q + b_q;
      endcase
    end
  end

  logic misaligned;
  assign misaligned = (is_lw || is_sw) && (alu_res[1:0] != 2'b00);

  // Word index keeps only the low address bits, so higher addresses wrap.
  logic [AW-1:0] mem_idx;
  assign mem_idx = alu_q[AW+1:2];

  logic accept;
  assign accept      = instr_valid && instr_ready;
  assign instr_ready = (state == S_IDLE);
  assign dbg_state   = state;
  assign dbg_data    = (dbg_addr == 5'd0) ? '0 : regs[dbg_addr];

  // Next state and the retire information that gets registered onto the outputs
  logic        retire, ret_ill, ret_tk;
  logic [15:0] ret_off;

  always_comb begin
    state_nx = state;
    retire   = 1'b0;
    ret_ill  = 1'b0;
    ret_tk   = 1'b0;
    ret_off  = 16'h0000;
    case (state)
      S_IDLE: begin
        if (accept) state_nx = S_DECODE;
      end
      S_DECODE: begin
        if (!legal) begin
          state_nx = S_IDLE;
          retire   = 1'b1;
          ret_ill  = 1'b1;
        end else begin
          state_nx = S_EXEC;
        end
      end
      S_EXEC: begin
        if (is_beq) begin
          state_nx = S_IDLE;
          retire   = 1'b1;
          ret_tk   = (a_q == b_q);
          ret_off  = ir[15:0];
        end else if (misaligned) begin
          state_nx = S_IDLE;
          retire   = 1'b1;
          ret_ill  = 1'b1;
        end else if (is_lw || is_sw) begin
          state_nx = S_MEM;
        end else begin
          state_nx = S_WB;
        end
      end
      S_MEM: begin
        if (is_lw) begin
          state_nx = S_WB;
        end else begin
          state_nx = S_IDLE;
          retire   = 1'b1;
        end
      end
      S_WB: begin
        state_nx = S_IDLE;
        retire   = 1'b1;
      end
      default: state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset) state <= S_IDLE;
    else        state <= state_nx;
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      done          <= 1'b0;
      illegal       <= 1'b0;
      branch_taken  <= 1'b0;
      branch_offset <= 16'h0000;
    end else begin
      done          <= retire;
      illegal       <= ret_ill;
      branch_taken  <= ret_tk;
      branch_offset <= ret_off;
    end
  end

  // Datapath. Reset clears every architectural word. Because reset has
  // priority, any write still pending in MEM/WB is dropped.
  always_ff @(posedge clock) begin
    if (!reset) begin
      ir    <= '0;
      a_q   <= '0;
      b_q   <= '0;
      imm_q <= '0;
      alu_q <= '0;
      mdr_q <= '0;
      for (int i = 0; i < 32; i++) regs[i] <= '0;
      for (int j = 0; j < MEM_DEPTH; j++) mem[j] <= '0;
    end else begin
      if (accept) ir <= instr;
      if (state == S_DECODE) begin
        a_q   <= regs[rs];
        b_q   <= regs[rt];
        imm_q <= imm_ext;
      end
      if (state == S_EXEC) alu_q <= alu_res;
      if (state == S_MEM) begin
        if (is_sw) mem[mem_idx] <= b_q;
        mdr_q <= mem[mem_idx];
      end
      if (state == S_WB && dest != 5'd0)
        regs[dest] <= is_lw ? mdr_q : alu_q;
    end
  end

endmodule

// File: tb/tb_mipscpu_multicycle.sv
// tb_mipscpu_multicycle
// Directed bench for mipscpu_multicycle. Each instruction pushes its expected
// retire record (latency, illegal, branch_taken, branch_offset) onto exp_q.
// The record is popped when done is seen. Register contents are checked
// through the debug port.
module tb_mipscpu_multicycle;
  localparam int DATA_W    = 32;
  localparam int MEM_DEPTH = 128;
  localparam int EW        = 22;  // {lat[3:0], illegal, taken, offset[15:0]}

  logic              clock = 1'b0;
  logic              reset;
  logic [31:0]       instr;
  logic              instr_valid;
  logic              instr_ready;
  logic              done, illegal, branch_taken;
  logic [15:0]       branch_offset;
  logic [4:0]        dbg_addr;
  logic [DATA_W-1:0] dbg_data;
  logic [2:0]        dbg_state;

  mipscpu_multicycle #(.DATA_W(DATA_W), .MEM_DEPTH(MEM_DEPTH)) dut (
    .clock(clock), .reset(reset), .instr(instr), .instr_valid(instr_valid),
    .instr_ready(instr_ready), .done(done), .illegal(illegal),
    .branch_taken(branch_taken), .branch_offset(branch_offset),
    .dbg_addr(dbg_addr), .dbg_data(dbg_data), .dbg_state(dbg_state)
  );

  // Clock
  always #5 clock = ~clock;

  int total = 0;
  int bad   = 0;
  logic [EW-1:0] exp_q[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_reg(input logic [4:0] idx, input logic [31:0] exp);
    dbg_addr = idx;
    #1;
    check($sformatf("reg r%0d", idx), dbg_data, exp);
  endtask

  // Driver. It is entered at a negedge and returns at the negedge of the done
  // cycle. A following call therefore drives during that same cycle, which
  // gives back-to-back accepts.
  task automatic run(input string tag, input logic [31:0] ins, input int lat,
                     input logic ill, input logic tk, input logic [15:0] off);
    int n;
    logic [EW-1:0] e;
    exp_q.push_back({4'(lat), ill, tk, off});
    n = 0;
    while (!instr_ready && n < 20) begin
      @(negedge clock);
      n++;
    end
    instr       = ins;
    instr_valid = 1'b1;
    @(posedge clock);
    #1;
    instr_valid = 1'b0;
    instr       = 32'h0;
    n = 0;
    do begin
      @(negedge clock);
      n++;
    end while (!done && n < 10);
    e = exp_q.pop_front();
    check({tag, " latency"}, done ? 32'(n) : 32'd15, 32'(e[21:18]));
    check({tag, " illegal"}, 32'(illegal), 32'(e[17]));
    check({tag, " taken"},   32'(branch_taken), 32'(e[16]));
    check({tag, " offset"},  32'(branch_offset), 32'(e[15:0]));
    check({tag, " ready"},   32'(instr_ready), 32'd1);
  endtask

  logic [31:0] lw_wrap;

  initial begin
    reset       = 1'b0;
    instr       = 32'h0;
    instr_valid = 1'b0;
    dbg_addr    = 5'd0;
    lw_wrap     = 32'h8C0C0000 | 32'(8 + 4 * MEM_DEPTH);  // lw r12,(8+4*depth)(r0)

    // Reset
    repeat (3) @(posedge clock);
    @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    check("reset ready",  32'(instr_ready), 32'd1);
    check("reset done",   32'(done), 32'd0);
    check("reset illegal", 32'(illegal), 32'd0);
    check("reset taken",  32'(branch_taken), 32'd0);
    check("reset offset", 32'(branch_offset), 32'd0);
    check("reset state",  32'(dbg_state), 32'd0);
    check_reg(5'd1, 32'h0);

    // addi
    run("addi r1", 32'h20010005, 4, 1'b0, 1'b0, 16'h0);
    check_reg(5'd1, 32'd5);
    run("addi r2", 32'h2002FFFD, 4, 1'b0, 1'b0, 16'h0);
    check_reg(5'd2, 32'hFFFFFFFD);

    // R-type
    run("add r3", 32'h00221820, 4, 1'b0, 1'b0, 16'h0);
    check_reg(5'd3, 32'd2);
    run("slt r4", 32'h0041202A, 4, 1'b0, 1'b0, 16'h0);
    check_reg(5'd4, 32'd1);
    run("sub r5", 32'h00412822, 4, 1'b0, 1'b0, 16'h0);
    check_reg(5'd5, 32'hFFFFFFF8);
    run("and r9", 32'h00224824, 4, 1'b0, 1'b0, 16'h0);
    check_reg(5'd9, 32'd5);
    run("or r10", 32'h00225025, 4, 1'b0, 1'b0, 16'h0);
    check_reg(5'd10, 32'hFFFFFFFD);
    run("nor r11", 32'h00225827, 4, 1'b0, 1'b0, 16'h0);
    check_reg(5'd11, 32'h00000002);
    run("add r0", 32'h00210020, 4, 1'b0, 1'b0, 16'h0);
    check_reg(5'd0, 32'h0);

    // Memory, including the wrapped address
    run("sw r1,8", 32'hAC010008, 4, 1'b0, 1'b0, 16'h0);
    run("lw r6,8", 32'h8C060008, 5, 1'b0, 1'b0, 16'h0);
    check_reg(5'd6, 32'd5);
    run("lw wrap", lw_wrap, 5, 1'b0, 1'b0, 16'h0);
    check_reg(5'd12, 32'd5);

    // Branches
    run("beq taken", 32'h1021FFFC, 3, 1'b0, 1'b1, 16'hFFFC);
    run("beq not",   32'h10220001, 3, 1'b0, 1'b0, 16'h0001);

    // Illegal and misaligned instructions
    run("op 3F",    32'hFC000000, 2, 1'b1, 1'b0, 16'h0);
    run("funct 3F", 32'h0022183F, 2, 1'b1, 1'b0, 16'h0);
    check_reg(5'd3, 32'd2);
    run("lw r7,2",  32'h8C070002, 3, 1'b1, 1'b0, 16'h0);
    check_reg(5'd7, 32'h0);
    run("sw r1,1",  32'hAC010001, 3, 1'b1, 1'b0, 16'h0);
    run("lw r13,0", 32'h8C0D0000, 5, 1'b0, 1'b0, 16'h0);
    check_reg(5'd13, 32'h0);

    // Reset during EXEC of addi r8,r0,9
    instr       = 32'h20080009;
    instr_valid = 1'b1;
    @(posedge clock);
    #1;
    instr_valid = 1'b0;
    @(negedge clock);
    check("mid decode state", 32'(dbg_state), 32'd1);
    @(negedge clock);
    check("mid exec state", 32'(dbg_state), 32'd2);
    reset       = 1'b0;
    instr       = 32'h20010007;  // offered during reset, must be ignored
    instr_valid = 1'b1;
    @(negedge clock);
    check("mid reset done", 32'(done), 32'd0);
    reset       = 1'b0;
    @(negedge clock);
    reset       = 1'b1;
    instr_valid = 1'b0;
    instr       = 32'h0;
    @(negedge clock);
    check("post reset ready", 32'(instr_ready), 32'd1);
    check("post reset done",  32'(done), 32'd0);
    check("post reset state", 32'(dbg_state), 32'd0);
    @(negedge clock);
    check("post reset done2", 32'(done), 32'd0);
    check_reg(5'd8, 32'h0);
    check_reg(5'd1, 32'h0);
    run("lw after reset", 32'h8C0E0008, 5, 1'b0, 1'b0, 16'h0);
    check_reg(5'd14, 32'h0);
    run("addi after reset", 32'h20080009, 4, 1'b0, 1'b0, 16'h0);
    check_reg(5'd8, 32'd9);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Global time bound
  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/mipscpu_multicycle.md
MIPSCPU_MULTICYCLE -- requirements
Module: mipscpu_multicycle

Interface
REQ-001 Parameter DATA_W, default 32: datapath, register and memory word width; legal range 16..32.
REQ-002 Parameter MEM_DEPTH, default 128: data memory depth in words; power of two, 4..1024.
REQ-003 Port clock, input, 1: single clock; all state changes on its rising edge.
REQ-004 Port reset, input, 1: reset is synchronous and active-low.
REQ-005 Port instr, input, 32: MIPS instruction word; sampled only on accept.
REQ-006 Port instr_valid, input, 1: instr holds a valid instruction.
REQ-007 Port instr_ready, output, 1: core can accept an instruction this cycle.
REQ-008 Port done, output, 1: one-cycle retire pulse.
REQ-009 Port illegal, output, 1: retired instruction was illegal or misaligned; valid only while done=1.
REQ-010 Port branch_taken, output, 1: retired beq had equal operands; valid only while done=1.
REQ-011 Port branch_offset, output, 16: imm field of the retired beq; valid only while done=1.
REQ-012 Port dbg_addr, input, 5: debug register-file read index.
REQ-013 Port dbg_data, output, DATA_W: combinational value of register[dbg_addr]; always 0 for index 0.

Function
REQ-014 Accept occurs when instr_valid=1 and instr_ready=1 on a rising edge; instr is latched into an internal IR; instr_valid while instr_ready=0 is ignored.
REQ-015 instr_ready shall be 1 exactly when state=IDLE.
REQ-016 States and transitions: IDLE -> DECODE on accept; DECODE -> EXEC, or -> IDLE if illegal; EXEC -> WB for R-type/addi, -> MEM for lw/sw, -> IDLE for beq or misaligned access; MEM -> WB for lw, -> IDLE for sw; WB -> IDLE.
REQ-017 Supported: opcode 0 with funct 32 add, 34 sub, 36 and, 37 or, 39 nor, 42 slt; opcode 8 addi; 35 lw; 43 sw; 4 beq; any other opcode or funct is illegal.
REQ-018 DECODE latches A=reg[rs], B=reg[rt], imm sign-extended from 16 bits to DATA_W.
REQ-019 Arithmetic is modulo 2^DATA_W; slt is a signed compare giving 1 or 0; lw/sw/addi compute A+imm; beq compares A==B.
REQ-020 Memory address is a byte address: bits [1:0] must be 00, otherwise the access is misaligned; word index = address bits [log2(MEM_DEPTH)+1:2]; upper bits are ignored, so addresses wrap.
REQ-021 Destination register is rd for R-type and rt for addi/lw; a write to register 0 is discarded.
REQ-022 The register write occurs on the edge leaving WB; the sw memory write occurs on the edge leaving MEM; the lw read data is registered in MEM.
REQ-023 With accept in cycle 0, done=1 in cycle 2 for illegal, cycle 3 for beq or misaligned, cycle 4 for R-type/addi/sw, cycle 5 for lw; instr_ready=1 in the same cycle as done, allowing back-to-back accept.
REQ-024 done, illegal, branch_taken and branch_offset are registered; they are 0 in all cycles other than the done cycle.
REQ-025 Illegal or misaligned instructions shall modify no register or memory location.

Reset
REQ-026 reset=0 at a rising edge forces: state IDLE; all registers and all memory words to 0; done, illegal, branch_taken to 0; branch_offset to 0.
REQ-027 Reset mid-instruction aborts it with no pending register or memory write and no done pulse; instr_valid during reset is ignored.
REQ-028 instr_ready=1 in the first cycle after reset is released.

Verification
REQ-029 Reset, then accept 0x20010005 (addi r1,r0,5) -> done in cycle 4, illegal=0, dbg_addr=1 reads 5.
REQ-030 With r1=5 and r2=-3 (addi 0x2002FFFD): add r3,r1,r2 -> r3=2; slt r4,r2,r1 -> r4=1; sub r5,r2,r1 -> r5=-8; add r0,r1,r1 -> dbg_addr=0 reads 0.
REQ-031 sw r1,8(r0) then lw r6,8(r0), each accepted in its done cycle -> sw done in cycle 4, lw done in cycle 5, r6=5; lw at byte address 8+4*MEM_DEPTH also returns 5 (wrap).
REQ-032 beq r1,r1,0xFFFC -> done in cycle 3, branch_taken=1, branch_offset=0xFFFC; beq r1,r2,1 -> branch_taken=0.
REQ-033 Opcode 0x3F -> done in cycle 2 with illegal=1; lw r7,2(r0) -> done in cycle 3 with illegal=1 and r7 unchanged.
REQ-034 reset=0 asserted in the EXEC cycle of addi r8,r0,9 -> no done pulse, r8=0, and instr_ready=1 in the cycle after reset is released.
